// File: rtl/pulse_train_gen_if.sv
// Control/status bundle between a sequencer (master) and pulse_train_gen (slave).
interface pulse_train_gen_if #(
  parameter int CNT_W = 8,
  parameter int WID_W = 8
);
  logic             start;
  logic [CNT_W-1:0] num_pulses;
  logic [WID_W-1:0] high_cycles;
  logic [WID_W-1:0] low_cycles;
  logic             abort;
  logic             a;
  logic             rose_strobe;
  logic             busy;
  logic             done;

  modport master (
    output start, num_pulses, high_cycles, low_cycles, abort,
    input  a, rose_strobe, busy, done
  );

  modport slave (
    input  start, num_pulses, high_cycles, low_cycles, abort,
    output a, rose_strobe, busy, done
  );
endinterface

// File: rtl/pulse_train_gen.sv
// Programmable pulse-train source on line `a`, one clean rising edge per pulse.
// Define PULSE_TRAIN_SVA_EN to compile the built-in concurrent assertions.
//
// state  | meaning
// S_IDLE | waiting for start
// S_HIGH | a=1, phase counter counts down the latched high length
// S_LOW  | a=0, phase counter counts down the latched low length
// S_DONE | one-cycle completion flag, then back to idle
module pulse_train_gen #(
  parameter int CNT_W = 8,
  parameter int WID_W = 8
) (
  input logic clk,
  input logic rst,
  pulse_train_gen_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_DONE} state_t;

  localparam logic [CNT_W-1:0] ONE_C = 1;
  localparam logic [WID_W-1:0] ONE_W = 1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] pulse_cnt, pulse_cnt_nxt;
  logic [WID_W-1:0] phase_cnt, phase_cnt_nxt;
  logic [WID_W-1:0] h_len, h_len_nxt;
  logic [WID_W-1:0] l_len, l_len_nxt;
  logic [WID_W-1:0] h_eff, l_eff;
  logic             a_q, rose_q, busy_q, done_q;
  logic             a_nxt, rose_nxt, busy_nxt, done_nxt;

  // Zero-length phases are stretched to one cycle so every pulse is visible.
  assign h_eff = (bus.high_cycles == '0) ? ONE_W : bus.high_cycles;
  assign l_eff = (bus.low_cycles == '0) ? ONE_W : bus.low_cycles;

  always_comb begin
    state_nxt     = state;
    pulse_cnt_nxt = pulse_cnt;
    phase_cnt_nxt = phase_cnt;
    h_len_nxt     = h_len;
    l_len_nxt     = l_len;
    a_nxt         = 1'b0;
    rose_nxt      = 1'b0;
    busy_nxt      = 1'b0;
    done_nxt      = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          h_len_nxt = h_eff;
          l_len_nxt = l_eff;
          if (bus.num_pulses != '0) begin
            state_nxt     = S_HIGH;
            pulse_cnt_nxt = bus.num_pulses;
            phase_cnt_nxt = h_eff - ONE_W;
            a_nxt         = 1'b1;
            rose_nxt      = 1'b1;
            busy_nxt      = 1'b1;
          end else begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
          end
        end
      end
      S_HIGH: begin
        if (bus.abort) begin
          state_nxt     = S_IDLE;
          pulse_cnt_nxt = '0;
          phase_cnt_nxt = '0;
        end else if (phase_cnt == '0) begin
          state_nxt     = S_LOW;
          phase_cnt_nxt = l_len - ONE_W;
          busy_nxt      = 1'b1;
        end else begin
          phase_cnt_nxt = phase_cnt - ONE_W;
          a_nxt         = 1'b1;
          busy_nxt      = 1'b1;
        end
      end
      S_LOW: begin
        if (bus.abort) begin
          state_nxt     = S_IDLE;
          pulse_cnt_nxt = '0;
          phase_cnt_nxt = '0;
        end else if (phase_cnt == '0) begin
          // pulse_cnt still includes the pulse just finishing
          if (pulse_cnt == ONE_C) begin
            state_nxt     = S_DONE;
            pulse_cnt_nxt = '0;
            done_nxt      = 1'b1;
          end else begin
            state_nxt     = S_HIGH;
            pulse_cnt_nxt = pulse_cnt - ONE_C;
            phase_cnt_nxt = h_len - ONE_W;
            a_nxt         = 1'b1;
            rose_nxt      = 1'b1;
            busy_nxt      = 1'b1;
          end
        end else begin
          phase_cnt_nxt = phase_cnt - ONE_W;
          busy_nxt      = 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pulse_cnt <= '0;
      phase_cnt <= '0;
      h_len     <= '0;
      l_len     <= '0;
      a_q       <= 1'b0;
      rose_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      pulse_cnt <= pulse_cnt_nxt;
      phase_cnt <= phase_cnt_nxt;
      h_len     <= h_len_nxt;
      l_len     <= l_len_nxt;
      a_q       <= a_nxt;
      rose_q    <= rose_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
    end
  end

  assign bus.a           = a_q;
  assign bus.rose_strobe = rose_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

`ifdef PULSE_TRAIN_SVA_EN
  logic [WID_W-1:0] hi_run;

  // Length of the current run of a=1, compared against h_len when a falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      hi_run <= '0;
    else if (a_q) hi_run <= hi_run + ONE_W;
    else          hi_run <= '0;
  end

  a_rose_strobe: assert property (@(posedge clk) disable iff (rst)
    $rose(a_q) == rose_q)
    else $error("rose(a) and rose_strobe disagree at %0t", $time);

  a_high_len: assert property (@(posedge clk) disable iff (rst)
    ($fell(a_q) && !$past(bus.abort)) |-> (hi_run == h_len))
    else $error("high run length differs from latched length at %0t", $time);

  a_busy_fall: assert property (@(posedge clk) disable iff (rst)
    $fell(busy_q) |-> (done_q || $past(bus.abort)))
    else $error("busy fell without done or abort at %0t", $time);

  a_done_single: assert property (@(posedge clk) disable iff (rst)
    done_q |=> !done_q)
    else $error("done high on two consecutive cycles at %0t", $time);

  c_two_pulses: cover property (@(posedge clk) disable iff (rst)
    rose_q ##1 (!done_q) [*1:$] ##1 rose_q);
`endif

endmodule

// File: tb/tb_pulse_train_gen.sv
// Randomized self-checking bench for pulse_train_gen against a closed-form
// per-cycle model of the pulse train (period H+L, done one cycle after N*(H+L)).
module tb_pulse_train_gen;
  localparam int CNT_W = 8;
  localparam int WID_W = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  pulse_train_gen_if #(.CNT_W(CNT_W), .WID_W(WID_W)) bus ();

  pulse_train_gen #(.CNT_W(CNT_W), .WID_W(WID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk_eq({tag, " a"},    int'(bus.a), 0);
    chk_eq({tag, " rose"}, int'(bus.rose_strobe), 0);
    chk_eq({tag, " busy"}, int'(bus.busy), 0);
    chk_eq({tag, " done"}, int'(bus.done), 0);
  endtask

  // k = 1 is the first edge that sees start. abort_at = edge at which abort
  // is sampled (0 = never). hold keeps start high through two back-to-back trains.
  task automatic run_train(input int n, input int h, input int l,
                           input int abort_at, input bit hold);
    int  he, le, p, t, kmax, kk, ph, rises, strobes, exp_rises;
    bit  aborted, ea, er, eb, ed;
    logic prev_a;
    he = (h == 0) ? 1 : h;
    le = (l == 0) ? 1 : l;
    p  = he + le;
    t  = n * p;
    kmax    = hold ? 2 * (t + 2) : t + 2;
    aborted = (abort_at >= 2) && (abort_at <= t + 1);
    @(negedge clk);
    bus.num_pulses  = CNT_W'(n);
    bus.high_cycles = WID_W'(h);
    bus.low_cycles  = WID_W'(l);
    bus.start       = 1'b1;
    bus.abort       = (abort_at == 1);
    prev_a  = bus.a;
    rises   = 0;
    strobes = 0;
    for (int k = 1; k <= kmax; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        bus.start = hold;
        if (!hold) begin
          bus.num_pulses  = CNT_W'($urandom);
          bus.high_cycles = WID_W'($urandom);
          bus.low_cycles  = WID_W'($urandom);
        end
      end
      kk = ((k - 1) % (t + 2)) + 1;
      ea = 0; er = 0; eb = 0; ed = 0;
      if (!(aborted && k >= abort_at)) begin
        if (kk <= t) begin
          ph = (kk - 1) % p;
          ea = (ph < he);
          er = (ph == 0);
          eb = 1;
        end else if (kk == t + 1) begin
          ed = 1;
        end
      end
      chk_eq($sformatf("a n=%0d h=%0d l=%0d k=%0d", n, h, l, k),    int'(bus.a), int'(ea));
      chk_eq($sformatf("rose n=%0d h=%0d l=%0d k=%0d", n, h, l, k), int'(bus.rose_strobe), int'(er));
      chk_eq($sformatf("busy n=%0d h=%0d l=%0d k=%0d", n, h, l, k), int'(bus.busy), int'(eb));
      chk_eq($sformatf("done n=%0d h=%0d l=%0d k=%0d", n, h, l, k), int'(bus.done), int'(ed));
      if (bus.a === 1'b1 && prev_a !== 1'b1) rises++;
      if (bus.rose_strobe === 1'b1) strobes++;
      prev_a    = bus.a;
      bus.abort = (k + 1 == abort_at);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    if (aborted) begin
      exp_rises = (abort_at - 1 + p - 1) / p;
      if (exp_rises > n) exp_rises = n;
    end else begin
      exp_rises = hold ? 2 * n : n;
    end
    chk_eq($sformatf("rises n=%0d h=%0d l=%0d", n, h, l),   rises, exp_rises);
    chk_eq($sformatf("strobes n=%0d h=%0d l=%0d", n, h, l), strobes, exp_rises);
  endtask

  task automatic reset_mid_train();
    @(negedge clk);
    bus.num_pulses  = 8'd5;
    bus.high_cycles = 8'd3;
    bus.low_cycles  = 8'd2;
    bus.start       = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk_eq("pre-reset a", int'(bus.a), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("async reset");
    @(posedge clk);
    #1;
    check_idle_outputs("held reset");
    @(negedge clk);
    rst = 1'b0;
    run_train(5, 3, 2, 0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, h, l, mode, t, ab;
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.num_pulses  = '0;
    bus.high_cycles = '0;
    bus.low_cycles  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    run_train(3, 2, 3, 0, 1'b0);
    run_train(0, 5, 5, 0, 1'b0);
    run_train(2, 0, 0, 0, 1'b0);
    run_train(4, 1, 1, 5, 1'b0);
    run_train(1, 1, 1, 0, 1'b0);
    reset_mid_train();
    run_train(2, 2, 1, 0, 1'b1);
    run_train(3, 1, 2, 1, 1'b0);
    run_train(2, 1, 1, 6, 1'b0);
    run_train(2, 1, 1, 5, 1'b0);
    run_train(255, 1, 1, 0, 1'b0);
    run_train(1, 255, 255, 0, 1'b0);

    repeat (25) begin
      n    = $urandom_range(0, 6);
      h    = $urandom_range(0, 4);
      l    = $urandom_range(0, 4);
      mode = $urandom_range(0, 3);
      t    = n * (((h == 0) ? 1 : h) + ((l == 0) ? 1 : l));
      ab   = (mode == 0) ? $urandom_range(1, t + 2) : 0;
      run_train(n, h, l, ab, mode == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
- Stimulus-side block that drives a single-bit line `a` with a programmed train of pulses. Each pulse produces exactly one clean rising edge.
- Counterpart to the edge-detect (`$rose`) checkers used on the same line: those observe edges, this block generates them deterministically.
- Used in the assertion benches and as an on-chip test-pattern source. Start/busy/done handshake toward a controlling sequencer.

Parameters:
- CNT_W, 8, width of the pulse-count field.
- WID_W, 8, width of the high- and low-phase length fields, in clock cycles.

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a train; sampled only in IDLE
- num_pulses  in  CNT_W  number of pulses; 0 = empty train
- high_cycles  in  WID_W  high-phase length; 0 treated as 1
- low_cycles  in  WID_W  low-phase length; 0 treated as 1
- abort  in  1  synchronous cancel of a running train
- a  out  1  generated pulse line (registered)
- rose_strobe  out  1  1-cycle flag, high in the first cycle `a` is 1 for each pulse
- busy  out  1  high in HIGH and LOW states
- done  out  1  1-cycle completion flag

Behaviour:
- Reset (async, rst=1): state=IDLE, a=0, rose_strobe=0, busy=0, done=0, all counters 0. Takes effect immediately, including mid-train; no done is issued.
- All outputs are registered. No combinational path from inputs to outputs.
- FSM states: IDLE, HIGH, LOW, DONE.
- Parameter latch: on an accepted start, latch num_pulses, max(high_cycles,1) and max(low_cycles,1). Input changes during a train are ignored.
- IDLE:
  - start=1 and num_pulses>0 -> HIGH next cycle. That cycle a=1, rose_strobe=1, busy=1.
  - start=1 and num_pulses=0 -> DONE next cycle. `a` stays 0.
  - start=0 -> stay in IDLE.
- HIGH: a=1 for exactly H latched cycles, then -> LOW. rose_strobe is high only in the first HIGH cycle.
- LOW: a=0 for exactly L latched cycles.
  - Pulses remaining -> HIGH, with a new rose_strobe.
  - Last pulse finished -> DONE.
- DONE: done=1, busy=0, a=0 for one cycle, then -> IDLE.
- Timing: start sampled at edge 0 gives
  - pulse k (k=0..N-1) rises at edge 1+k*(H+L);
  - done is high at edge 1+N*(H+L);
  - busy is high for N*(H+L) cycles.
- start while busy or in DONE: ignored and not queued.
- abort:
  - In HIGH or LOW: next cycle a=0, busy=0, done=0, state=IDLE. The remaining pulse count is discarded.
  - In IDLE or DONE: no effect.
  - abort and start in the same IDLE cycle: start wins.
- Counters:
  - pulse counter is CNT_W bits; phase counter is WID_W bits.
  - Maximum values (num_pulses=2^CNT_W-1, phase length 2^WID_W-1) are supported with no wrap.
- Invariants:
  - Exactly one rising edge on `a` per pulse, and none at any other time.
  - `a` is 0 whenever busy=0.

Optional Feature:
- Macro: PULSE_TRAIN_SVA_EN.
- Defined: the block contains concurrent assertions, clocked on posedge clk and disabled iff rst:
  - `$rose(a)` iff rose_strobe;
  - a high run lasts exactly the latched H;
  - `$fell(busy)` implies done or a prior abort;
  - done is never high on two consecutive cycles;
  - a covergroup-free cover property on a train of at least 2 pulses.
  - Any violation reports `$error` with `$time`.
- Undefined: no assertion code is compiled. RTL behaviour is identical.

Test Plan:
- N=3, H=2, L=3, start at edge 0 -> `a` rises at edges 1, 6, 11, each with rose_strobe; done at edge 16; busy high on edges 1-15; exactly 3 `$rose(a)`.
- N=0, start -> done high on edge 1; `a` and busy stay 0; no rose_strobe.
- N=2, H=0, L=0 (treated as 1) -> `a` pattern from edge 1 is 1,0,1,0; done at edge 5.
- N=4, H=1, L=1, abort asserted at edge 4 -> `a`=0 and busy=0 from edge 5; no done; a new start at edge 6 begins a fresh train with rise at edge 7.
- N=5, H=3, L=2, rst pulsed asynchronously mid-HIGH at t=23ns -> `a`, busy and state clear immediately; no done; a re-start after release runs a full 5-pulse train.
- start held high through a full N=2 train -> the second start is taken only from IDLE, one cycle after done; no overlapping trains; rose_strobe count equals 2 per train.
